// File: rtl/rc4_pkg.sv
// Shared RC4 definitions: the PRGA state encoding, the default message length and the
// plaintext acceptance test used by the key-search loop.
package rc4_pkg;

   localparam int         MSG_LEN_DEF = 32;
   localparam logic [7:0] ASCII_LO    = 8'd97;
   localparam logic [7:0] ASCII_HI    = 8'd122;
   localparam logic [7:0] ASCII_SP    = 8'd32;

   typedef enum logic [3:0] {
      ST_IDLE,
      ST_READ_I,
      ST_WAIT_I,
      ST_GET_I,
      ST_READ_J,
      ST_WAIT_J,
      ST_GET_J,
      ST_WRITE_I,
      ST_WRITE_J,
      ST_READ_F,
      ST_WAIT_F,
      ST_GET_F,
      ST_WRITE_D,
      ST_DONE
   } state_t;

   function automatic logic is_ok(input logic [7:0] b);
      return ((b >= ASCII_LO) && (b <= ASCII_HI)) || (b == ASCII_SP);
   endfunction

endpackage

// File: rtl/rc4_prga_decrypt.sv
// RC4 keystream generator and decryptor: walks the scheduled S array, XORs each keystream
// byte with the encrypted ROM, writes the decrypted RAM and flags all-lowercase plaintext.
module rc4_prga_decrypt
   import rc4_pkg::*;
#(
   parameter int MSG_LEN = MSG_LEN_DEF,
   parameter int KW      = (MSG_LEN > 1) ? $clog2(MSG_LEN) : 1
) (
   input  logic          CLOCK_50,
   input  logic          reset_n,
   input  logic          start,
   output logic          done,
   output logic          valid,
   output logic [7:0]    s_address,
   output logic [7:0]    s_data,
   output logic          s_wren,
   input  logic [7:0]    s_q,
   output logic [KW-1:0] e_address,
   input  logic [7:0]    e_q,
   output logic [KW-1:0] d_address,
   output logic [7:0]    d_data,
   output logic          d_wren
);

   state_t        r_state;
   logic [7:0]    r_i;
   logic [7:0]    r_j;
   logic [7:0]    r_si;
   logic [7:0]    r_sj;
   logic [KW-1:0] r_k;
   logic          r_valid_acc;

   logic          w_last;
   logic          w_ok;

   assign w_last = (r_k == KW'(MSG_LEN - 1));
   assign w_ok   = is_ok(d_data);

   // Memories register their address, so every output set in a state's branch is what the
   // memory samples at the end of the following state.
   always_ff @(posedge CLOCK_50) begin
      if (!reset_n) begin
         r_state     <= ST_IDLE;
         r_i         <= '0;
         r_j         <= '0;
         r_k         <= '0;
         r_valid_acc <= 1'b1;
         done        <= 1'b0;
         valid       <= 1'b0;
         s_address   <= '0;
         s_data      <= '0;
         s_wren      <= 1'b0;
         e_address   <= '0;
         d_address   <= '0;
         d_data      <= '0;
         d_wren      <= 1'b0;
      end else begin
         s_wren <= 1'b0;
         d_wren <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               if (start) r_state <= ST_READ_I;
            end
            ST_READ_I: begin
               r_i       <= r_i + 8'd1;
               s_address <= r_i + 8'd1;
               r_state   <= ST_WAIT_I;
            end
            ST_WAIT_I: r_state <= ST_GET_I;
            ST_GET_I: begin
               r_si    <= s_q;
               r_j     <= r_j + s_q;
               r_state <= ST_READ_J;
            end
            ST_READ_J: begin
               s_address <= r_j;
               r_state   <= ST_WAIT_J;
            end
            ST_WAIT_J: r_state <= ST_GET_J;
            ST_GET_J: begin
               r_sj    <= s_q;
               r_state <= ST_WRITE_I;
            end
            // When i==j both writes hit one address and the later one (si) wins.
            ST_WRITE_I: begin
               s_address <= r_i;
               s_data    <= r_sj;
               s_wren    <= 1'b1;
               r_state   <= ST_WRITE_J;
            end
            ST_WRITE_J: begin
               s_address <= r_j;
               s_data    <= r_si;
               s_wren    <= 1'b1;
               r_state   <= ST_READ_F;
            end
            ST_READ_F: begin
               s_address <= r_si + r_sj;
               e_address <= r_k;
               r_state   <= ST_WAIT_F;
            end
            ST_WAIT_F: r_state <= ST_GET_F;
            ST_GET_F: begin
               d_data  <= s_q ^ e_q;
               r_state <= ST_WRITE_D;
            end
            ST_WRITE_D: begin
               d_address   <= r_k;
               d_wren      <= 1'b1;
               r_valid_acc <= r_valid_acc & w_ok;
               if (w_last) begin
                  done    <= 1'b1;
                  valid   <= r_valid_acc & w_ok;
                  r_state <= ST_DONE;
               end else begin
                  r_k     <= r_k + 1'b1;
                  r_state <= ST_READ_I;
               end
            end
            ST_DONE: begin
               if (!start) begin
                  done        <= 1'b0;
                  valid       <= 1'b0;
                  r_i         <= '0;
                  r_j         <= '0;
                  r_k         <= '0;
                  r_valid_acc <= 1'b1;
                  r_state     <= ST_IDLE;
               end
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_rc4_prga_decrypt.sv
// Scoreboard bench for rc4_prga_decrypt: a 4-byte and a 256-byte instance, each with
// registered-address memory models, checked against a plain-arithmetic RC4 reference.
module tb_rc4_prga_decrypt;
   import rc4_pkg::*;

   localparam int NA  = 4;
   localparam int NB  = 256;
   localparam int KWA = 2;
   localparam int KWB = 8;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic reset_n;

   logic           a_start, a_done, a_valid, a_s_wren, a_d_wren;
   logic [7:0]     a_s_address, a_s_data, a_s_q, a_e_q, a_d_data;
   logic [KWA-1:0] a_e_address, a_d_address;

   logic           b_start, b_done, b_valid, b_s_wren, b_d_wren;
   logic [7:0]     b_s_address, b_s_data, b_s_q, b_e_q, b_d_data;
   logic [KWB-1:0] b_e_address, b_d_address;

   rc4_prga_decrypt #(.MSG_LEN(NA)) u_dut_a (
      .CLOCK_50(clk), .reset_n(reset_n), .start(a_start), .done(a_done), .valid(a_valid),
      .s_address(a_s_address), .s_data(a_s_data), .s_wren(a_s_wren), .s_q(a_s_q),
      .e_address(a_e_address), .e_q(a_e_q),
      .d_address(a_d_address), .d_data(a_d_data), .d_wren(a_d_wren));

   rc4_prga_decrypt #(.MSG_LEN(NB)) u_dut_b (
      .CLOCK_50(clk), .reset_n(reset_n), .start(b_start), .done(b_done), .valid(b_valid),
      .s_address(b_s_address), .s_data(b_s_data), .s_wren(b_s_wren), .s_q(b_s_q),
      .e_address(b_e_address), .e_q(b_e_q),
      .d_address(b_d_address), .d_data(b_d_data), .d_wren(b_d_wren));

   // Memory models: address registered, read data one clock later
   logic [7:0] a_smem [256];
   logic [7:0] a_sinit[256];
   logic [7:0] a_erom [NA];
   logic       a_ld;
   logic [7:0] b_smem [256];
   logic [7:0] b_sinit[256];
   logic [7:0] b_erom [NB];
   logic       b_ld;

   always @(posedge clk) begin
      if (a_ld) a_smem <= a_sinit;
      else if (a_s_wren) a_smem[a_s_address] <= a_s_data;
      a_s_q <= a_smem[a_s_address];
      a_e_q <= a_erom[a_e_address];
   end

   always @(posedge clk) begin
      if (b_ld) b_smem <= b_sinit;
      else if (b_s_wren) b_smem[b_s_address] <= b_s_data;
      b_s_q <= b_smem[b_s_address];
      b_e_q <= b_erom[b_e_address];
   end

   int checks = 0;
   int errors = 0;

   task automatic chk(input string nm, input int act, input int req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: actual %0h required %0h", nm, act, req);
      end
   endtask

   typedef struct packed {
      logic [7:0] addr;
      logic [7:0] data;
   } wr_t;

   wr_t a_exp_q[$];
   bit  a_vexp_q[$];
   wr_t b_exp_q[$];
   bit  b_vexp_q[$];
   bit  a_sb_en;
   wr_t a_item;
   wr_t b_item;
   bit  a_vitem;
   bit  b_vitem;
   logic a_done_d = 1'b0;
   logic b_done_d = 1'b0;
   int   b_wr_cnt = 0;

   // Monitors: pop expected writes / done-valid whenever the DUT presents them
   always @(negedge clk) begin
      if (reset_n && a_sb_en) begin
         if (a_d_wren) begin
            if (a_exp_q.size() == 0) begin
               checks++; errors++;
               $display("FAIL a_unexpected_write: actual addr %0h data %0h required none", a_d_address, a_d_data);
            end else begin
               a_item = a_exp_q.pop_front();
               chk("a_d_address", int'(a_d_address), int'(a_item.addr));
               chk("a_d_data", int'(a_d_data), int'(a_item.data));
            end
         end
         if (a_done && !a_done_d) begin
            if (a_vexp_q.size() == 0) begin
               checks++; errors++;
               $display("FAIL a_unexpected_done: actual done 1 required no completion");
            end else begin
               a_vitem = a_vexp_q.pop_front();
               chk("a_valid", int'(a_valid), int'(a_vitem));
            end
         end
      end
      a_done_d <= a_done;
   end

   always @(negedge clk) begin
      if (reset_n && b_d_wren) begin
         b_wr_cnt <= b_wr_cnt + 1;
         if (b_exp_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL b_unexpected_write: actual addr %0h data %0h required none", b_d_address, b_d_data);
         end else begin
            b_item = b_exp_q.pop_front();
            chk("b_d_address", int'(b_d_address), int'(b_item.addr));
            chk("b_d_data", int'(b_d_data), int'(b_item.data));
         end
      end
      if (reset_n && b_done && !b_done_d) begin
         if (b_vexp_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL b_unexpected_done: actual done 1 required no completion");
         end else begin
            b_vitem = b_vexp_q.pop_front();
            chk("b_valid", int'(b_valid), int'(b_vitem));
         end
      end
      b_done_d <= b_done;
   end

   // Reference model: textbook RC4 PRGA over byte arrays
   logic [7:0] s_img[256];
   logic [7:0] e_img[256];
   logic [7:0] m_s[256];
   logic [7:0] m_e[256];
   logic [7:0] m_d[256];

   task automatic set_model();
      for (int x = 0; x < 256; x++) begin
         m_s[x] = s_img[x];
         m_e[x] = e_img[x];
      end
   endtask

   task automatic run_model(input int n);
      int ii = 0;
      int jj = 0;
      logic [7:0] t;
      for (int k = 0; k < n; k++) begin
         ii = (ii + 1) % 256;
         jj = (jj + int'(m_s[ii])) % 256;
         t = m_s[ii]; m_s[ii] = m_s[jj]; m_s[jj] = t;
         m_d[k] = m_s[(int'(m_s[ii]) + int'(m_s[jj])) % 256] ^ m_e[k];
      end
   endtask

   function automatic bit plain_ok(input logic [7:0] b);
      return (b >= "a" && b <= "z") || b == " ";
   endfunction

   task automatic ksa_key();
      logic [7:0] key[3];
      int jj = 0;
      logic [7:0] t;
      key[0] = 8'h4B; key[1] = 8'h65; key[2] = 8'h79;
      for (int x = 0; x < 256; x++) s_img[x] = 8'(x);
      for (int x = 0; x < 256; x++) begin
         jj = (jj + int'(s_img[x]) + int'(key[x % 3])) % 256;
         t = s_img[x]; s_img[x] = s_img[jj]; s_img[jj] = t;
      end
   endtask

   task automatic rand_perm();
      int r;
      logic [7:0] t;
      for (int x = 0; x < 256; x++) s_img[x] = 8'(x);
      for (int x = 255; x > 0; x--) begin
         r = $urandom_range(x, 0);
         t = s_img[x]; s_img[x] = s_img[r]; s_img[r] = t;
      end
   endtask

   task automatic load_a();
      for (int x = 0; x < 256; x++) a_sinit[x] = s_img[x];
      for (int x = 0; x < NA; x++) a_erom[x] = e_img[x];
      @(negedge clk); a_ld = 1'b1;
      @(negedge clk); a_ld = 1'b0;
   endtask

   task automatic load_b();
      for (int x = 0; x < 256; x++) b_sinit[x] = s_img[x];
      for (int x = 0; x < NB; x++) b_erom[x] = e_img[x];
      @(negedge clk); b_ld = 1'b1;
      @(negedge clk); b_ld = 1'b0;
   endtask

   task automatic push_a_model();
      bit ok = 1'b1;
      for (int k = 0; k < NA; k++) begin
         a_exp_q.push_back('{addr: 8'(k), data: m_d[k]});
         ok &= plain_ok(m_d[k]);
      end
      a_vexp_q.push_back(ok);
   endtask

   task automatic push_a_const(input logic [31:0] bytes, input bit v);
      for (int k = 0; k < NA; k++) a_exp_q.push_back('{addr: 8'(k), data: bytes[31-8*k -: 8]});
      a_vexp_q.push_back(v);
   endtask

   function automatic int s_diff_a();
      int n = 0;
      for (int x = 0; x < 256; x++) if (a_smem[x] !== m_s[x]) n++;
      return n;
   endfunction

   function automatic int s_diff_b();
      int n = 0;
      for (int x = 0; x < 256; x++) if (b_smem[x] !== m_s[x]) n++;
      return n;
   endfunction

   task automatic a_go(output int lat);
      @(negedge clk); a_start = 1'b1;
      @(posedge clk); #1; a_start = 1'b0; lat = 0;
      while (!a_done && lat < 4000) begin @(posedge clk); #1; lat++; end
      if (!a_done) begin
         checks++; errors++;
         $display("FAIL a_done_timeout: actual done 0 after %0d clocks required 1", lat);
      end
      repeat (3) @(posedge clk);
   endtask

   task automatic set_e4(input logic [31:0] bytes);
      for (int k = 0; k < 256; k++) e_img[k] = 8'h00;
      for (int k = 0; k < NA; k++) e_img[k] = bytes[31-8*k -: 8];
   endtask

   task automatic a_random_run(input bit want_ok);
      int lat;
      int r;
      rand_perm();
      for (int k = 0; k < 256; k++) e_img[k] = 8'($urandom);
      if (want_ok) begin
         set_model();
         for (int k = 0; k < 256; k++) m_e[k] = 8'h00;
         run_model(NA);
         for (int k = 0; k < NA; k++) begin
            r = $urandom_range(26, 0);
            e_img[k] = m_d[k] ^ ((r == 26) ? 8'd32 : 8'(97 + r));
         end
      end
      load_a();
      set_model(); run_model(NA); push_a_model();
      a_go(lat);
      chk("rand_latency", lat, 12 * NA);
      chk("rand_s_final", s_diff_a(), 0);
   endtask

   initial begin
      #2ms;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int lat;
      int cnt;
      reset_n = 1'b0; a_start = 1'b0; b_start = 1'b0; a_ld = 1'b0; b_ld = 1'b0; a_sb_en = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_done", int'(a_done), 0);
      chk("rst_valid", int'(a_valid), 0);
      chk("rst_s_wren", int'(a_s_wren), 0);
      chk("rst_d_wren", int'(a_d_wren), 0);
      chk("rst_s_address", int'(a_s_address), 0);
      chk("rst_d_address", int'(a_d_address), 0);
      @(negedge clk); reset_n = 1'b1;

      // Identity S, zero ciphertext
      for (int x = 0; x < 256; x++) s_img[x] = 8'(x);
      set_e4(32'h00000000);
      load_a();
      push_a_const(32'h0205070D, 1'b0);
      set_model(); run_model(NA);
      a_go(lat);
      chk("t1_S2", int'(a_smem[2]), 8'h03);
      chk("t1_S3", int'(a_smem[3]), 8'h05);
      chk("t1_S5", int'(a_smem[5]), 8'h02);
      chk("t1_s_final", s_diff_a(), 0);

      // "Key" schedule, "Plai" prefix of "Plaintext"
      ksa_key();
      set_e4(32'hBBF316E8);
      load_a();
      push_a_const(32'h506C6169, 1'b0);
      a_go(lat);

      // "Key" schedule, "aaaa", exact latency
      ksa_key();
      set_e4(32'h8AFE16E0);
      load_a();
      push_a_const(32'h61616161, 1'b1);
      a_go(lat);
      chk("t3_latency", lat, 48);

      // start toggling mid-run, then held past DONE
      ksa_key(); load_a();
      push_a_const(32'h61616161, 1'b1);
      @(negedge clk); a_start = 1'b1;
      @(posedge clk);
      for (int c = 0; c < 39; c++) begin
         @(negedge clk);
         if (c % 3 == 0) a_start = ~a_start;
      end
      @(negedge clk); a_start = 1'b1;
      cnt = 0;
      while (!a_done && cnt < 200) begin @(posedge clk); #1; cnt++; end
      chk("t4_done_reached", int'(a_done), 1);
      repeat (5) begin @(posedge clk); #1; chk("t4_done_hold", int'(a_done), 1); end
      @(negedge clk); a_start = 1'b0;
      @(posedge clk); #1;
      chk("t4_done_drop", int'(a_done), 0);
      repeat (3) @(posedge clk);
      #1;
      chk("t4_idle_state", int'(u_dut_a.r_state), int'(ST_IDLE));
      chk("t4_idle_d_wren", int'(a_d_wren), 0);

      // Reset mid-run, reload S and rerun
      ksa_key(); load_a();
      a_sb_en = 1'b0;
      @(negedge clk); a_start = 1'b1;
      @(posedge clk); #1; a_start = 1'b0;
      repeat (19) @(posedge clk);
      @(negedge clk); reset_n = 1'b0;
      @(posedge clk); #1;
      chk("t5_done", int'(a_done), 0);
      chk("t5_s_wren", int'(a_s_wren), 0);
      chk("t5_d_wren", int'(a_d_wren), 0);
      chk("t5_state", int'(u_dut_a.r_state), int'(ST_IDLE));
      @(negedge clk); reset_n = 1'b1; a_sb_en = 1'b1;
      ksa_key(); load_a();
      push_a_const(32'h61616161, 1'b1);
      a_go(lat);
      chk("t5_latency", lat, 48);

      // Randomized runs on the 4-byte instance
      for (int r = 0; r < 6; r++) a_random_run(r[0]);

      // Full 256-byte message
      rand_perm();
      for (int k = 0; k < 256; k++) e_img[k] = 8'($urandom);
      load_b();
      set_model(); run_model(NB);
      begin
         bit ok = 1'b1;
         for (int k = 0; k < NB; k++) begin
            b_exp_q.push_back('{addr: 8'(k), data: m_d[k]});
            ok &= plain_ok(m_d[k]);
         end
         b_vexp_q.push_back(ok);
      end
      @(negedge clk); b_start = 1'b1;
      @(posedge clk); #1; b_start = 1'b0; lat = 0;
      while (!b_done && lat < 5000) begin @(posedge clk); #1; lat++; end
      chk("t6_latency", lat, 12 * NB);
      repeat (30) @(posedge clk);
      #1;
      chk("t6_write_count", b_wr_cnt, 256);
      chk("t6_queue_left", b_exp_q.size(), 0);
      chk("t6_s_final", s_diff_b(), 0);

      chk("a_queue_left", a_exp_q.size(), 0);
      chk("a_valid_queue_left", a_vexp_q.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
